// File: rtl/mdu_div_sequencer.sv
// Multi-cycle integer divide/remainder sequencer: restoring division, one quotient bit per cycle.
// state | meaning
// IDLE  | waiting for start
// CALC  | shift/subtract, one quotient bit per cycle, MSB first
// ADJ   | sign correction and quotient/remainder select
// DONE  | Result valid, done pulse; accepts a back-to-back start
module mdu_div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       DivOp,
    input  logic [WIDTH-1:0] Op1,
    input  logic [WIDTH-1:0] Op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, ADJ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             op_rem;
    logic             neg_q;
    logic             neg_r;

    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             ovf;
    logic [WIDTH-1:0] special_res;
    logic [WIDTH+1:0] trial;
    logic [WIDTH+1:0] diff;
    logic             fits;
    logic [WIDTH-1:0] q_adj;
    logic [WIDTH-1:0] r_adj;
    logic [WIDTH-1:0] adj_res;

    always_comb begin
        op_signed   = ~DivOp[0];
        a_neg       = op_signed & Op1[WIDTH-1];
        b_neg       = op_signed & Op2[WIDTH-1];
        a_mag       = a_neg ? (~Op1 + 1'b1) : Op1;
        b_mag       = b_neg ? (~Op2 + 1'b1) : Op2;
        div_zero    = (Op2 == '0);
        ovf         = op_signed & (Op1 == {1'b1, {(WIDTH-1){1'b0}}}) & (Op2 == '1);
        special_res = div_zero ? (DivOp[1] ? Op1 : '1)
                               : (DivOp[1] ? '0  : Op1);

        // rem stays below the divisor, so the top trial bit is only a guard for the borrow
        trial = {rem, quo[WIDTH-1]};
        diff  = trial - {2'b00, divisor};
        fits  = ~diff[WIDTH+1];

        q_adj   = neg_q ? (~quo + 1'b1) : quo;
        r_adj   = neg_r ? (~rem[WIDTH-1:0] + 1'b1) : rem[WIDTH-1:0];
        adj_res = op_rem ? r_adj : q_adj;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            op_rem  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Result  <= '0;
        end else if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        op_rem  <= DivOp[1];
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        divisor <= b_mag;
                        quo     <= a_mag;
                        rem     <= '0;
                        count   <= '0;
                        if (div_zero || ovf) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            Result <= special_res;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem   <= fits ? diff[WIDTH:0] : trial[WIDTH:0];
                    quo   <= {quo[WIDTH-2:0], fits};
                    count <= count + 1'b1;
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    Result <= adj_res;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// Directed bench for mdu_div_sequencer: latency, results, special cases, flush, reset.
module tb_mdu_div_sequencer;

    localparam int W = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         flush;
    logic [1:0]   DivOp;
    logic [W-1:0] Op1;
    logic [W-1:0] Op2;
    logic         busy;
    logic         done;
    logic [W-1:0] Result;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mdu_div_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .DivOp  (DivOp),
        .Op1    (Op1),
        .Op2    (Op2),
        .busy   (busy),
        .done   (done),
        .Result (Result)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start is high during cycle 0; returns observing cycle 1
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        DivOp = op;
        Op1   = a;
        Op2   = b;
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int limit, output int at, output int nbusy);
        at    = -1;
        nbusy = 0;
        while (cyc <= limit) begin
            if (done) begin
                at = cyc;
                break;
            end
            if (busy) nbusy++;
            tick();
        end
    endtask

    task automatic op_check(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] exp, input int lat);
        int at, nb;
        launch(op, a, b);
        run_to_done(40, at, nb);
        chk({tag, " latency"}, 64'(at), 64'(lat));
        chk({tag, " result"}, 64'(Result), 64'(exp));
        chk({tag, " busy cycles"}, 64'(nb), 64'(lat - 1));
    endtask

    initial begin
        int at, nb, ndone, nbusy;
        rst = 1'b1; start = 1'b0; flush = 1'b0;
        DivOp = OP_DIV; Op1 = '0; Op2 = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset Result", 64'(Result), 64'(0));
        rst = 1'b0;
        tick();
        chk("idle after reset busy", 64'(busy), 64'(0));

        // basic unsigned divide and Result hold
        launch(OP_DIVU, 100, 7);
        chk("divu c1 busy", 64'(busy), 64'(1));
        run_to_done(40, at, nb);
        chk("divu done cycle", 64'(at), 64'(34));
        chk("divu busy cycles", 64'(nb), 64'(33));
        chk("divu result", 64'(Result), 64'(14));
        tick();
        chk("divu done one cycle", 64'(done), 64'(0));
        while (cyc < 40) tick();
        chk("divu hold c40", 64'(Result), 64'(14));
        chk("divu idle busy c40", 64'(busy), 64'(0));

        // start during busy is ignored
        launch(OP_DIVU, 100, 7);
        while (cyc < 10) tick();
        Op1 = 9; Op2 = 3; start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(40, at, nb);
        chk("ignored start done cycle", 64'(at), 64'(34));
        chk("ignored start result", 64'(Result), 64'(14));
        tick();

        op_check("rem -7/2",    OP_REM,  32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34);
        op_check("div -7/2",    OP_DIV,  32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34);
        op_check("div -100/7",  OP_DIV,  32'hFFFF_FF9C, 7, 32'hFFFF_FFF2, 34);
        op_check("rem -100/7",  OP_REM,  32'hFFFF_FF9C, 7, 32'hFFFF_FFFE, 34);
        op_check("div 100/-7",  OP_DIV,  100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34);
        op_check("rem 100/-7",  OP_REM,  100, 32'hFFFF_FFF9, 2, 34);
        op_check("remu 100/7",  OP_REMU, 100, 7, 2, 34);
        op_check("divu max/1",  OP_DIVU, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 34);
        op_check("divu big/small", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0000, 1, 34);
        op_check("remu 7/100",  OP_REMU, 7, 100, 7, 34);
        op_check("div mostneg/2", OP_DIV, 32'h8000_0000, 2, 32'hC000_0000, 34);

        op_check("divu 5/0",    OP_DIVU, 5, 0, 32'hFFFF_FFFF, 1);
        op_check("remu 5/0",    OP_REMU, 5, 0, 5, 1);
        op_check("rem -5/0",    OP_REM,  32'hFFFF_FFFB, 0, 32'hFFFF_FFFB, 1);
        op_check("rem ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 1);
        op_check("div ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        tick();

        // flush mid-operation, with a start in the same cycle
        launch(OP_DIVU, 100, 7);
        while (cyc < 15) tick();
        flush = 1'b1; start = 1'b1; Op1 = 81; Op2 = 9;
        tick();
        flush = 1'b0; start = 1'b0;
        chk("flush busy c16", 64'(busy), 64'(0));
        chk("flush done c16", 64'(done), 64'(0));
        chk("flush Result kept", 64'(Result), 64'(32'h8000_0000));
        tick();
        chk("flush no done c17", 64'(done), 64'(0));
        chk("flush start discarded", 64'(busy), 64'(0));
        launch(OP_DIVU, 100, 7);
        run_to_done(40, at, nb);
        chk("after flush done cycle", 64'(at), 64'(34));
        chk("after flush result", 64'(Result), 64'(14));
        tick();

        // back-to-back from DONE
        launch(OP_DIVU, 100, 7);
        run_to_done(40, at, nb);
        chk("b2b first done", 64'(at), 64'(34));
        DivOp = OP_DIVU; Op1 = 81; Op2 = 9; start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy c35", 64'(busy), 64'(1));
        run_to_done(80, at, nb);
        chk("b2b second done", 64'(at), 64'(68));
        chk("b2b result", 64'(Result), 64'(9));

        // reset during the second operation
        launch(OP_DIVU, 100, 7);
        run_to_done(40, at, nb);
        chk("rst run first result", 64'(Result), 64'(14));
        DivOp = OP_DIVU; Op1 = 81; Op2 = 9; start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < 50) tick();
        rst = 1'b1; start = 1'b1; Op1 = 9; Op2 = 3;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rst busy c51", 64'(busy), 64'(0));
        chk("rst done c51", 64'(done), 64'(0));
        chk("rst Result c51", 64'(Result), 64'(0));
        ndone = 0; nbusy = 0;
        while (cyc < 75) begin
            if (done) ndone++;
            if (busy) nbusy++;
            tick();
        end
        chk("rst no done pulse", 64'(ndone), 64'(0));
        chk("rst start ignored", 64'(nbusy), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_div_sequencer.md
MDU_DIV_SEQUENCER -- requirements
Module: mdu_div_sequencer

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be >= 4 and a power of two.
REQ-002 Ports, one per line, clock and reset first:
- clk  in  1  single clock; all state SHALL update on its rising edge only.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request to begin a divide/remainder operation.
- flush  in  1  abort the operation in progress (pipeline redirect).
- DivOp  in  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- Op1  in  WIDTH  dividend (rs1).
- Op2  in  WIDTH  divisor (rs2).
- busy  out  1  high while the operation is in progress; the CPU SHALL treat it as a stall.
- done  out  1  one-cycle pulse; Result is valid in that cycle.
- Result  out  WIDTH  registered quotient or remainder.

Function
REQ-003 States SHALL be IDLE, CALC, ADJ and DONE.
REQ-004 In IDLE or DONE, start=1 SHALL latch DivOp, Op1 and Op2. Call that cycle 0.
REQ-005 Divide-by-zero (Op2==0) at cycle 0 SHALL go directly to DONE.
- Quotient = all ones; remainder = Op1.
- done SHALL be high in cycle 1.
REQ-006 Signed overflow (DIV/REM, Op1 = most-negative, Op2 = all ones) SHALL go directly to DONE.
- Quotient = Op1; remainder = 0.
- done SHALL be high in cycle 1.
REQ-007 Every other start SHALL enter CALC at cycle 1.
- Signed ops divide the magnitudes; result signs are recorded at latch time.
- Quotient sign = sign(Op1) XOR sign(Op2); remainder sign = sign(Op1).
REQ-008 CALC SHALL perform restoring division, one quotient bit per cycle, MSB first.
- A log2(WIDTH)+1-bit counter runs from 0 to WIDTH-1.
- The partial-remainder register is WIDTH+1 bits wide.
REQ-009 After the cycle with count WIDTH-1, the FSM SHALL enter ADJ (cycle WIDTH+1). ADJ applies two's-complement sign correction and selects quotient or remainder per DivOp.
REQ-010 ADJ SHALL be followed unconditionally by DONE. done=1 in cycle WIDTH+2, i.e. a total latency of WIDTH+2 cycles.
REQ-011 Division results SHALL wrap to WIDTH bits; no exception or flag output exists.
REQ-012 busy SHALL be 1 exactly in CALC and ADJ; it SHALL be 0 in IDLE and DONE.
REQ-013 start SHALL be ignored while busy=1. Latched operands SHALL NOT change mid-operation.
REQ-014 DONE SHALL last one cycle.
- Next state is CALC (or DONE via the special-case path) if start=1; otherwise IDLE.
- This permits back-to-back operations with no idle gap.
REQ-015 Result SHALL be written only when entering DONE and SHALL hold until the next DONE entry. Operand inputs SHALL have no combinational path to any output.
REQ-016 flush=1 in any state SHALL force IDLE on the next edge.
- Result is unchanged; no done pulse is issued.
- A start in the same cycle as flush SHALL be discarded.
REQ-017 Priority SHALL be rst > flush > start.

Reset
REQ-018 rst=1 SHALL, on the next edge:
- force IDLE;
- clear the counter and internal registers;
- drive busy=0, done=0 and Result=0.
REQ-019 Reset mid-operation SHALL abandon the operation without a done pulse. start sampled during rst=1 SHALL be ignored.

Verification
REQ-020 DIVU, Op1=100, Op2=7, start in cycle 0 -> busy=1 in cycles 1-33; done=1 and Result=14 in cycle 34 only; Result still 14 in cycle 40.
REQ-021 REM, Op1=-7 (0xFFFFFFF9), Op2=2 -> Result=0xFFFFFFFF (-1) at cycle 34. DIV with the same operands -> Result=0xFFFFFFFD (-3).
REQ-022 DIVU Op1=5, Op2=0 -> done in cycle 1, Result=0xFFFFFFFF. REMU Op1=5, Op2=0 -> Result=5. DIV Op1=0x80000000, Op2=0xFFFFFFFF -> Result=0x80000000 in cycle 1.
REQ-023 DIVU 100/7, with start pulsed again in cycle 10 with Op1=9, Op2=3 -> second start ignored; done at cycle 34 with Result=14.
REQ-024 flush in cycle 15 of DIVU 100/7 -> IDLE and busy=0 in cycle 16; no done pulse; Result keeps its prior value; a new start in cycle 17 completes normally in cycle 51.
REQ-025 Back-to-back: start held in the DONE cycle (34) with DIVU 81/9 -> busy in cycle 35; done with Result=9 in cycle 68. rst asserted in cycle 50 -> busy=0, done=0, Result=0 from cycle 51; no done pulse.
